// File: rtl/seg_data_encoder.sv
// Captures a binary count and two status codes, converts the count to BCD by
// shift-add-3, and presents four active-low 7-segment patterns plus refresh strobe.
module seg_data_encoder #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter bit          LZ_BLANK    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] valor,
    input  logic [3:0] actividad_cod,
    input  logic [3:0] estado_cod,
    input  logic       valor_valid,
    input  logic       disp_on,
    output logic       busy,
    output logic [6:0] Unidades,
    output logic [6:0] Decenas,
    output logic [6:0] Actividad,
    output logic [6:0] Estado,
    output logic       Disp_Enable,
    output logic       disp_tick
);

    localparam int unsigned CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t        state, state_next;
    logic [6:0]    bin;
    logic [7:0]    bcd;
    logic [7:0]    bcd_adj;
    logic [2:0]    bit_cnt;
    logic [3:0]    act_q;
    logic [3:0]    est_q;
    logic          over_range;
    logic          have_data;
    logic [CW-1:0] refresh_cnt;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
        endcase
    endfunction

    always_comb begin
        bcd_adj[3:0] = (bcd[3:0] >= 4'd5) ? bcd[3:0] + 4'd3 : bcd[3:0];
        bcd_adj[7:4] = (bcd[7:4] >= 4'd5) ? bcd[7:4] + 4'd3 : bcd[7:4];
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (valor_valid) state_next = SHIFT;
            SHIFT:   if (bit_cnt == 3'd6) state_next = LOAD;
            LOAD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            bin        <= '0;
            bcd        <= '0;
            bit_cnt    <= '0;
            act_q      <= '0;
            est_q      <= '0;
            over_range <= 1'b0;
            have_data  <= 1'b0;
            Unidades   <= '1;
            Decenas    <= '1;
            Actividad  <= '1;
            Estado     <= '1;
        end else begin
            case (state)
                IDLE: if (valor_valid) begin
                    bin        <= valor;
                    act_q      <= actividad_cod;
                    est_q      <= estado_cod;
                    over_range <= (valor >= 7'd100);
                    bcd        <= '0;
                    bit_cnt    <= '0;
                end
                SHIFT: begin
                    // Full 15-bit shift; the bcd MSB that falls off only matters for over-range values.
                    {bcd, bin} <= {bcd_adj, bin} << 1;
                    bit_cnt    <= bit_cnt + 3'd1;
                end
                LOAD: begin
                    Actividad <= hex7(act_q);
                    Estado    <= hex7(est_q);
                    have_data <= 1'b1;
                    if (over_range) begin
                        Unidades <= 7'h3F;
                        Decenas  <= 7'h3F;
                    end else begin
                        Unidades <= hex7(bcd[3:0]);
                        Decenas  <= (LZ_BLANK && bcd[7:4] == 4'd0) ? 7'h7F : hex7(bcd[7:4]);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) Disp_Enable <= 1'b0;
        else     Disp_Enable <= disp_on & have_data;
    end

    always_ff @(posedge clk) begin
        if (rst)                          refresh_cnt <= '0;
        else if (refresh_cnt == REFRESH_LAST) refresh_cnt <= '0;
        else                              refresh_cnt <= refresh_cnt + CW'(1);
    end

    assign disp_tick = (refresh_cnt == REFRESH_LAST);

endmodule
